// File: rtl/fan_row_collector.sv
// Collects completed row sums from the FAN output lanes, accumulates them per row
// across the K-passes of a tile, then drains touched rows in ascending order.
module fan_row_collector #(
  parameter int NUM_IN  = 32,
  parameter int DW_DATA = 32,
  parameter int DW_ROW  = 4,
  parameter int DW_CTRL = 4
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [NUM_IN*(DW_DATA+DW_ROW+DW_CTRL)-1:0] in_i,
  input  logic                                       in_valid_i,
  input  logic                                       in_last_i,
  output logic                                       in_ready_o,
  output logic                                       out_valid_o,
  input  logic                                       out_ready_i,
  output logic [DW_ROW-1:0]                          out_row_o,
  output logic [DW_DATA-1:0]                         out_data_o,
  output logic                                       out_last_o,
  output logic                                       err_conflict_o
);

  localparam int DW_LINE  = DW_DATA + DW_ROW + DW_CTRL;
  localparam int NUM_ROWS = 1 << DW_ROW;

  typedef enum logic {ACCUM, DRAIN} state_e;

  state_e                    state_q, state_d;
  logic                      lastPending_q, lastPending_d;
  logic [NUM_IN*DW_LINE-1:0] s1Beat_q;
  logic                      s1Valid_q, s1Last_q;
  logic [DW_DATA-1:0]        acc_q [NUM_ROWS];
  logic [DW_DATA-1:0]        acc_d [NUM_ROWS];
  logic [NUM_ROWS-1:0]       touched_q, touched_d;
  logic                      errConflict_q;

  logic                      accept;
  logic                      drainFire;
  logic [NUM_ROWS-1:0]       rowHit;
  logic [NUM_ROWS-1:0]       rowDup;
  logic [DW_DATA-1:0]        rowAddend [NUM_ROWS];
  logic [DW_ROW-1:0]         ptr;
  logic [NUM_IN-1:0]         unusedCtrl;

  assign accept    = in_valid_i && in_ready_o;
  assign drainFire = out_valid_o && out_ready_i;

  // Scanning lanes upward means the first hit per row is the lowest lane; later hits flag a conflict.
  always_comb begin : laneSelect
    logic [DW_DATA-1:0] laneData;
    logic [DW_ROW-1:0]  laneRow;
    logic [DW_CTRL-1:0] laneCtrl;
    rowHit     = '0;
    rowDup     = '0;
    unusedCtrl = '0;
    laneData   = '0;
    laneRow    = '0;
    laneCtrl   = '0;
    for (int r = 0; r < NUM_ROWS; r++) rowAddend[r] = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      laneData      = s1Beat_q[k*DW_LINE +: DW_DATA];
      laneRow       = s1Beat_q[k*DW_LINE+DW_DATA +: DW_ROW];
      laneCtrl      = s1Beat_q[k*DW_LINE+DW_DATA+DW_ROW +: DW_CTRL];
      unusedCtrl[k] = ^laneCtrl[DW_CTRL-1:1];
      if (s1Valid_q && laneCtrl[0]) begin
        if (rowHit[laneRow]) begin
          rowDup[laneRow] = 1'b1;
        end else begin
          rowHit[laneRow]    = 1'b1;
          rowAddend[laneRow] = laneData;
        end
      end
    end
  end

  always_comb begin
    ptr = '0;
    for (int r = NUM_ROWS - 1; r >= 0; r--) begin
      if (touched_q[r]) ptr = DW_ROW'(r);
    end
  end

  // Accumulation and draining never overlap: S1 is empty for the whole drain.
  always_comb begin
    touched_d = touched_q | rowHit;
    for (int r = 0; r < NUM_ROWS; r++) begin
      acc_d[r] = rowHit[r] ? acc_q[r] + rowAddend[r] : acc_q[r];
    end
    if (drainFire) begin
      acc_d[ptr]     = '0;
      touched_d[ptr] = 1'b0;
    end
  end

  always_comb begin
    lastPending_d = lastPending_q;
    if (s1Valid_q && s1Last_q) lastPending_d = 1'b0;
    if (accept && in_last_i)   lastPending_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ACCUM;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM: if (s1Valid_q && s1Last_q) state_d = DRAIN;
      DRAIN: if (touched_d == '0)       state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  always_comb begin
    in_ready_o  = !rst && (state_q == ACCUM) && !lastPending_q;
    out_valid_o = !rst && (state_q == DRAIN) && (touched_q != '0);
    out_last_o  = out_valid_o && ((touched_q & (touched_q - NUM_ROWS'(1))) == '0);
    out_row_o   = ptr;
    out_data_o  = acc_q[ptr];
  end

  assign err_conflict_o = errConflict_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      lastPending_q <= 1'b0;
      s1Beat_q      <= '0;
      s1Valid_q     <= 1'b0;
      s1Last_q      <= 1'b0;
      touched_q     <= '0;
      errConflict_q <= 1'b0;
      for (int r = 0; r < NUM_ROWS; r++) acc_q[r] <= '0;
    end else begin
      lastPending_q <= lastPending_d;
      s1Valid_q     <= accept;
      s1Last_q      <= accept && in_last_i;
      if (accept) s1Beat_q <= in_i;
      touched_q     <= touched_d;
      errConflict_q <= errConflict_q | (|rowDup);
      for (int r = 0; r < NUM_ROWS; r++) acc_q[r] <= acc_d[r];
    end
  end

endmodule

// File: tb/tb_fan_row_collector.sv
// Scoreboard bench for fan_row_collector: a lane-level model pushes expected results
// per tile, a monitor pops them on each output handshake.
module tb_fan_row_collector;

  localparam int NUM_IN   = 32;
  localparam int DW_DATA  = 32;
  localparam int DW_ROW   = 4;
  localparam int DW_CTRL  = 4;
  localparam int DW_LINE  = DW_DATA + DW_ROW + DW_CTRL;
  localparam int NUM_ROWS = 16;

  typedef struct packed {
    logic [DW_ROW-1:0]  row;
    logic [DW_DATA-1:0] data;
    logic               last;
  } result_t;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic [NUM_IN*DW_LINE-1:0] inBus = '0;
  logic                      inValid = 1'b0;
  logic                      inLast = 1'b0;
  logic                      inReady;
  logic                      outValid;
  logic                      outReady = 1'b1;
  logic [DW_ROW-1:0]         outRow;
  logic [DW_DATA-1:0]        outData;
  logic                      outLast;
  logic                      errConflict;

  int checks = 0;
  int errors = 0;
  int cycleCount = 0;

  result_t                   sbQueue[$];
  logic [DW_DATA-1:0]        modelAcc [NUM_ROWS];
  logic [NUM_ROWS-1:0]       modelTouched = '0;
  logic                      modelConflict = 1'b0;
  logic [NUM_IN*DW_LINE-1:0] lanesBuf = '0;

  logic                      holdValid = 1'b0;
  logic [DW_ROW-1:0]         holdRow;
  logic [DW_DATA-1:0]        holdData;
  logic                      holdLast;

  fan_row_collector dut (
    .clk           (clk),
    .rst           (rst),
    .in_i          (inBus),
    .in_valid_i    (inValid),
    .in_last_i     (inLast),
    .in_ready_o    (inReady),
    .out_valid_o   (outValid),
    .out_ready_i   (outReady),
    .out_row_o     (outRow),
    .out_data_o    (outData),
    .out_last_o    (outLast),
    .err_conflict_o(errConflict)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount++;

  // Every handshake consumes one expected result; a stalled result must not change.
  always @(negedge clk) begin
    result_t expRes;
    if (rst) begin
      holdValid = 1'b0;
    end else begin
      if (holdValid) begin
        checks++;
        if (outValid !== 1'b1 || outRow !== holdRow || outData !== holdData || outLast !== holdLast) begin
          errors++;
          $display("[TB] FAIL hold_stable: got v=%b row=%0d data=%h last=%b, required v=1 row=%0d data=%h last=%b",
                   outValid, outRow, outData, outLast, holdRow, holdData, holdLast);
        end
      end
      if (outValid === 1'b1 && outReady === 1'b1) begin
        checks++;
        if (sbQueue.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_result: got row=%0d data=%h last=%b, required no result",
                   outRow, outData, outLast);
        end else begin
          expRes = sbQueue.pop_front();
          if (outRow !== expRes.row || outData !== expRes.data || outLast !== expRes.last) begin
            errors++;
            $display("[TB] FAIL result: got row=%0d data=%h last=%b, required row=%0d data=%h last=%b",
                     outRow, outData, outLast, expRes.row, expRes.data, expRes.last);
          end
        end
      end
      holdValid = (outValid === 1'b1 && outReady === 1'b0);
      holdRow   = outRow;
      holdData  = outData;
      holdLast  = outLast;
    end
  end

  task automatic modelClear();
    for (int r = 0; r < NUM_ROWS; r++) modelAcc[r] = '0;
    modelTouched = '0;
  endtask

  // Non-sum lanes get random payload and random high ctrl bits, which must be ignored.
  task automatic clearLanes();
    for (int k = 0; k < NUM_IN; k++)
      lanesBuf[k*DW_LINE +: DW_LINE] = {3'($urandom), 1'b0, 4'($urandom), 32'($urandom)};
  endtask

  task automatic setLane(input int k, input logic [DW_ROW-1:0] row, input logic [DW_DATA-1:0] data);
    lanesBuf[k*DW_LINE +: DW_LINE] = {3'($urandom), 1'b1, row, data};
  endtask

  // Caller sits just after a rising edge; returns just after the accepting edge.
  task automatic sendBeat(input logic last, output int acceptCycle);
    logic [DW_LINE-1:0]  lane;
    logic [DW_ROW-1:0]   row;
    logic [NUM_ROWS-1:0] seen;
    int                  remaining;
    inBus       = lanesBuf;
    inValid     = 1'b1;
    inLast      = last;
    acceptCycle = -1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (inReady === 1'b1) begin
        acceptCycle = cycleCount;
        break;
      end
    end
    checks++;
    if (acceptCycle < 0) begin
      errors++;
      $display("[TB] FAIL beat_accept: got in_ready=%b for 200 cycles, required 1", inReady);
    end
    @(posedge clk);
    #1;
    inValid = 1'b0;
    inLast  = 1'b0;
    seen = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      lane = lanesBuf[k*DW_LINE +: DW_LINE];
      if (lane[DW_DATA+DW_ROW]) begin
        row = lane[DW_DATA +: DW_ROW];
        if (seen[row]) begin
          modelConflict = 1'b1;
        end else begin
          seen[row]         = 1'b1;
          modelAcc[row]     = modelAcc[row] + lane[DW_DATA-1:0];
          modelTouched[row] = 1'b1;
        end
      end
    end
    if (last) begin
      remaining = $countones(modelTouched);
      for (int r = 0; r < NUM_ROWS; r++) begin
        if (modelTouched[r]) begin
          remaining--;
          sbQueue.push_back('{row: DW_ROW'(r), data: modelAcc[r], last: (remaining == 0)});
        end
      end
      modelClear();
    end
  endtask

  task automatic waitDrain(input string name);
    bit done = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (sbQueue.size() == 0 && inReady === 1'b1) begin
        done = 1'b1;
        break;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("[TB] FAIL %s_drain: got pending=%0d in_ready=%b, required pending=0 in_ready=1",
               name, sbQueue.size(), inReady);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (inReady !== 1'b0 || outValid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_hold: got in_ready=%b out_valid=%b, required 0 0", inReady, outValid);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    modelClear();
    modelConflict = 1'b0;
    @(negedge clk);
    checks++;
    if (inReady !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_in_ready: got %b, required 1", inReady);
    end
    checks++;
    if (outValid !== 1'b0 || outLast !== 1'b0 || outRow !== '0 || outData !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got v=%b last=%b row=%0d data=%h, required all 0",
               outValid, outLast, outRow, outData);
    end
    checks++;
    if (errConflict !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_err: got %b, required 0", errConflict);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    int acc;
    outReady = 1'b1;
    clearLanes();
    setLane(0, 4'd3, 32'd5);
    setLane(7, 4'd1, 32'd9);
    sendBeat(1'b1, acc);
    @(negedge clk);
    checks++;
    if (inReady !== 1'b0 || outValid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_t1: got in_ready=%b out_valid=%b, required 0 0", inReady, outValid);
    end
    @(negedge clk);
    checks++;
    if (outValid !== 1'b1 || outRow !== 4'd1 || outLast !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_t2: got v=%b row=%0d last=%b, required v=1 row=1 last=0", outValid, outRow, outLast);
    end
    @(negedge clk);
    checks++;
    if (outValid !== 1'b1 || outRow !== 4'd3 || outLast !== 1'b1) begin
      errors++;
      $display("[TB] FAIL single_t3: got v=%b row=%0d last=%b, required v=1 row=3 last=1", outValid, outRow, outLast);
    end
    @(negedge clk);
    checks++;
    if (inReady !== 1'b1 || outValid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_ready_back: got in_ready=%b out_valid=%b, required 1 0", inReady, outValid);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_accum_wrap();
    int  acc;
    bit  seenValid = 1'b0;
    clearLanes(); setLane(3, 4'd2, 32'd10);         sendBeat(1'b0, acc);
    clearLanes(); setLane(20, 4'd2, -32'sd3);       sendBeat(1'b0, acc);
    clearLanes(); setLane(0, 4'd2, 32'h7FFF_FFFF);  sendBeat(1'b0, acc);
    clearLanes(); setLane(31, 4'd2, 32'd1);         sendBeat(1'b1, acc);
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (outValid === 1'b1) begin
        seenValid = 1'b1;
        break;
      end
    end
    // 10 - 3 + 0x7FFFFFFF + 1 wraps past the sign bit.
    checks++;
    if (!seenValid || outRow !== 4'd2 || outData !== 32'h8000_0007 || outLast !== 1'b1) begin
      errors++;
      $display("[TB] FAIL accum_wrap: got v=%b row=%0d data=%h last=%b, required v=1 row=2 data=80000007 last=1",
               outValid, outRow, outData, outLast);
    end
    waitDrain("accum_wrap");
  endtask

  task automatic test_backpressure();
    int acc;
    bit seenValid = 1'b0;
    outReady = 1'b0;
    clearLanes();
    setLane(31, 4'd4, 32'd111);
    setLane(0, 4'd8, 32'd222);
    setLane(16, 4'd15, 32'd333);
    sendBeat(1'b1, acc);
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (outValid === 1'b1) begin
        seenValid = 1'b1;
        break;
      end
    end
    for (int n = 0; n < 5; n++) begin
      checks++;
      if (!seenValid || outValid !== 1'b1 || outRow !== 4'd4 || outData !== 32'd111) begin
        errors++;
        $display("[TB] FAIL backpressure_stall: got v=%b row=%0d data=%h, required v=1 row=4 data=6f",
                 outValid, outRow, outData);
      end
      @(negedge clk);
    end
    for (int n = 0; n < 40 && sbQueue.size() > 0; n++) begin
      @(posedge clk);
      #1;
      outReady = ~outReady;
    end
    outReady = 1'b1;
    waitDrain("backpressure");
  endtask

  task automatic test_conflict();
    int acc;
    clearLanes();
    setLane(4, 4'd6, 32'd2);
    setLane(9, 4'd6, 32'd100);
    setLane(12, 4'd1, 32'd3);
    sendBeat(1'b1, acc);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (errConflict !== modelConflict) begin
      errors++;
      $display("[TB] FAIL conflict_flag: got %b, required %b", errConflict, modelConflict);
    end
    waitDrain("conflict");
    clearLanes();
    setLane(2, 4'd0, 32'd1);
    sendBeat(1'b1, acc);
    waitDrain("conflict_next");
    checks++;
    if (errConflict !== 1'b1) begin
      errors++;
      $display("[TB] FAIL conflict_sticky: got %b, required 1", errConflict);
    end
  endtask

  task automatic test_empty();
    int acc;
    clearLanes();
    sendBeat(1'b1, acc);
    @(negedge clk);
    checks++;
    if (inReady !== 1'b0) begin
      errors++;
      $display("[TB] FAIL empty_t1: got in_ready=%b, required 0", inReady);
    end
    @(negedge clk);
    checks++;
    if (inReady !== 1'b0 || outValid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL empty_t2: got in_ready=%b out_valid=%b, required 0 0", inReady, outValid);
    end
    @(negedge clk);
    checks++;
    if (inReady !== 1'b1 || outValid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL empty_t3: got in_ready=%b out_valid=%b, required 1 0", inReady, outValid);
    end
    @(posedge clk);
    #1;
    clearLanes();
    setLane(5, 4'd9, 32'd42);
    sendBeat(1'b1, acc);
    waitDrain("empty_next");
  endtask

  task automatic test_back_to_back();
    int accA;
    int accB;
    clearLanes();
    setLane(10, 4'd5, 32'd77);
    sendBeat(1'b1, accA);
    clearLanes();
    setLane(1, 4'd11, 32'd88);
    sendBeat(1'b1, accB);
    checks++;
    if (accB - accA !== 3) begin
      errors++;
      $display("[TB] FAIL back_to_back_gap: got %0d cycles, required 3", accB - accA);
    end
    waitDrain("back_to_back");
  endtask

  task automatic test_reset_mid_drain();
    int acc;
    outReady = 1'b1;
    clearLanes();
    setLane(0, 4'd0, 32'd1);
    setLane(1, 4'd3, 32'd2);
    setLane(2, 4'd7, 32'd3);
    setLane(3, 4'd12, 32'd4);
    sendBeat(1'b1, acc);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sbQueue.delete();
    modelClear();
    modelConflict = 1'b0;
    @(negedge clk);
    checks++;
    if (outValid !== 1'b0 || inReady !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_mid_drain: got out_valid=%b in_ready=%b, required 0 1", outValid, inReady);
    end
    checks++;
    if (errConflict !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_clears_err: got %b, required 0", errConflict);
    end
    @(posedge clk);
    #1;
    clearLanes();
    setLane(8, 4'd0, 32'd7);
    sendBeat(1'b1, acc);
    waitDrain("after_reset");
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish by 200000, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_accum_wrap();
    test_backpressure();
    test_conflict();
    test_empty();
    test_back_to_back();
    test_reset_mid_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
